// File: rtl/led_scan_driver.sv
// led_scan_driver: row-multiplexed LED frame scanner.
// Holds a ROWS x COLS frame and drives a 74HC595-style column chain plus
// one-hot row FETs. The shift of the next row overlaps display of the
// current one.
// Optional feature: define FRAME_DBUF_EN for a double-buffered frame RAM
// with a swap request/acknowledge (swap / swap_done).
module led_scan_driver #(
    parameter int ROWS        = 14,
    parameter int COLS        = 48,
    parameter int CLK_HALF    = 2,
    parameter int ON_CYCLES   = 512,
    parameter int DEAD_CYCLES = 4,
    localparam int RW         = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic            swap,
    output logic            sr_data,
    output logic            sr_clock,
    output logic            sr_latch,
    output logic            sr_enable,
    output logic [ROWS-1:0] fet_gate,
    output logic            frame_start,
    output logic            swap_done
);
    localparam int CMAX0 = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES : DEAD_CYCLES;
    localparam int CMAX  = (CMAX0 > CLK_HALF) ? CMAX0 : CLK_HALF;
    localparam int CW    = $clog2(CMAX + 3);
    localparam int BW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int HW    = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;

    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(CLK_HALF - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(COLS - 1);
    localparam logic [HW-1:0] HALF_LAST  = HW'(CLK_HALF - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

    typedef enum logic [1:0] {PRELOAD, BLANK, LATCH, ON} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [RW-1:0]   cur_row, next_row, snap_row;
    logic            start, row_adv, on_first;

    logic            busy, sr_clk;
    logic [COLS-1:0] shreg, snap_data;
    logic [BW-1:0]   bit_cnt;
    logic [HW-1:0]   half_cnt;
    logic            shift_last, shift_done;

    assign next_row   = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
    assign snap_row   = (state == PRELOAD) ? '0 : next_row;
    assign shift_last = busy && sr_clk && (half_cnt == HALF_LAST) && (bit_cnt == BIT_LAST);
    assign shift_done = !busy || shift_last;

`ifdef FRAME_DBUF_EN
    logic [COLS-1:0] ram [2][ROWS];
    logic            front, pending, swap_go;

    // Swap lands exactly on the row-0 snapshot so a frame is never torn.
    assign swap_go   = start && (snap_row == '0) && pending;
    assign snap_data = ram[front ^ swap_go][snap_row];
    assign swap_done = swap_go;

    // Frame RAM: writes always land in the back bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < ROWS; i++) ram[b][i] <= '0;
        end else if (wr_en && wr_row <= ROW_LAST) begin
            ram[~front][wr_row] <= wr_data;
        end
    end

    // Bank select and pending swap; extra requests while pending merge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front   <= 1'b0;
            pending <= 1'b0;
        end else begin
            front   <= front ^ swap_go;
            pending <= swap_go ? 1'b0 : (pending | swap);
        end
    end
`else
    logic [COLS-1:0] ram [ROWS];
    logic            unused_swap;

    assign unused_swap = swap;
    assign snap_data   = ram[snap_row];
    assign swap_done   = 1'b0;

    // Frame RAM: single bank shared by writer and scanner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) ram[i] <= '0;
        end else if (wr_en && wr_row <= ROW_LAST) begin
            ram[wr_row] <= wr_data;
        end
    end
`endif

    // Column shifter: CLK_HALF low then CLK_HALF high per bit, MSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            sr_clk   <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            half_cnt <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            sr_clk   <= 1'b0;
            shreg    <= snap_data;
            bit_cnt  <= '0;
            half_cnt <= '0;
        end else if (busy) begin
            if (half_cnt == HALF_LAST) begin
                half_cnt <= '0;
                sr_clk   <= ~sr_clk;
                if (sr_clk) begin
                    shreg <= shreg << 1;
                    if (bit_cnt == BIT_LAST) busy <= 1'b0;
                    else                     bit_cnt <= bit_cnt + BW'(1);
                end
            end else begin
                half_cnt <= half_cnt + HW'(1);
            end
        end
    end

    // Scan FSM state, shared phase counter, row pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= PRELOAD;
            cnt      <= '0;
            cur_row  <= '0;
            on_first <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            on_first <= (state_nx == ON) && (state != ON);
            if (row_adv) cur_row <= next_row;
        end
    end

    // Next-state logic. PRELOAD idles one cycle before its snapshot so a
    // write issued together with reset release is captured.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        start    = 1'b0;
        row_adv  = 1'b0;
        case (state)
            PRELOAD: begin
                if (cnt == '0) begin
                    cnt_nx = CW'(1);
                end else if (cnt == CW'(1)) begin
                    start  = 1'b1;
                    cnt_nx = CW'(2);
                end else if (shift_done) begin
                    state_nx = BLANK;
                    cnt_nx   = '0;
                end
            end
            BLANK: begin
                if (cnt == DEAD_LAST) begin
                    if (run) begin
                        state_nx = LATCH;
                        cnt_nx   = '0;
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            LATCH: begin
                if (cnt == LATCH_LAST) begin
                    state_nx = ON;
                    cnt_nx   = '0;
                    start    = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ON: begin
                if (cnt == ON_LAST && shift_done) begin
                    state_nx = BLANK;
                    cnt_nx   = '0;
                    row_adv  = 1'b1;
                end else if (cnt != ON_LAST) begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = PRELOAD;
        endcase
    end

    assign sr_data     = busy & shreg[COLS-1];
    assign sr_clock    = sr_clk;
    assign sr_latch    = (state == LATCH);
    assign sr_enable   = (state == ON);
    assign fet_gate    = (state == ON) ? (ROWS'(1) << cur_row) : '0;
    assign frame_start = on_first && (cur_row == '0);

endmodule

// File: tb/tb_led_scan_driver.sv
// Directed bench for led_scan_driver (ROWS=14, COLS=8, CLK_HALF=1,
// ON_CYCLES=40, DEAD_CYCLES=2) plus a shift-limited copy with ON_CYCLES=4.
`timescale 1ns/1ps
module tb_led_scan_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b1, run = 1'b0, wr_en = 1'b0, swap = 1'b0;
    logic [3:0]  wr_row = '0;
    logic [7:0]  wr_data = '0;

    logic        sr_data, sr_clock, sr_latch, sr_enable, frame_start, swap_done;
    logic [13:0] fet_gate;
    logic        s_sr_data, s_sr_clock, s_sr_latch, s_sr_enable, s_frame_start, s_swap_done;
    logic [13:0] s_fet_gate;

    int checks = 0, errors = 0;
    int hazard = 0, fs_cnt = 0, sd_cnt = 0;

`ifdef FRAME_DBUF_EN
    localparam logic [7:0] FIRST_EXP = 8'h00;
`else
    localparam logic [7:0] FIRST_EXP = 8'hA5;
`endif

    always #5 clk = ~clk;

    led_scan_driver #(.ROWS(14), .COLS(8), .CLK_HALF(1), .ON_CYCLES(40), .DEAD_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .run(run), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .swap(swap), .sr_data(sr_data), .sr_clock(sr_clock), .sr_latch(sr_latch),
        .sr_enable(sr_enable), .fet_gate(fet_gate), .frame_start(frame_start), .swap_done(swap_done));

    led_scan_driver #(.ROWS(14), .COLS(8), .CLK_HALF(1), .ON_CYCLES(4), .DEAD_CYCLES(2)) dut_s (
        .clk(clk), .rst(rst), .run(run), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .swap(swap), .sr_data(s_sr_data), .sr_clock(s_sr_clock), .sr_latch(s_sr_latch),
        .sr_enable(s_sr_enable), .fet_gate(s_fet_gate), .frame_start(s_frame_start),
        .swap_done(s_swap_done));

    // Invariant monitor and event counters, sampled 1ns after each falling edge.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if ($countones(fet_gate) > 1 || (fet_gate != 0 && sr_latch) ||
                (sr_enable != (fet_gate != 0)) || (frame_start && fet_gate != 14'h0001))
                hazard++;
            if ($countones(s_fet_gate) > 1 || (s_fet_gate != 0 && s_sr_latch) ||
                (s_sr_enable != (s_fet_gate != 0)) || (s_frame_start && s_fet_gate != 14'h0001))
                hazard++;
            if (frame_start) fs_cnt++;
            if (swap_done) sd_cnt++;
        end
    end

    // Follow one row from its first ON cycle through the following gap.
    task automatic run_row(input int r, input int wr_at, input logic [3:0] wr_r,
                           input logic [7:0] wr_d, input int stop_at, input int swap_at,
                           input int gap_max, output int on_len, output logic [7:0] shifted,
                           output int nrise, output int blanks, output int latches);
        logic [13:0] onehot;
        logic        prev;
        onehot = 14'(1) << r;
        on_len = 0; shifted = '0; nrise = 0; blanks = 0; latches = 0; prev = 1'b0;
        while (fet_gate == onehot && on_len < 1000) begin
            if (sr_clock && !prev) begin
                shifted = {shifted[6:0], sr_data};
                nrise++;
            end
            prev  = sr_clock;
            wr_en = (on_len == wr_at);
            if (on_len == wr_at) begin
                wr_row  = wr_r;
                wr_data = wr_d;
            end
            swap = (on_len == swap_at);
            if (on_len == stop_at) run = 1'b0;
            on_len++;
            @(negedge clk);
        end
        wr_en = 1'b0;
        swap  = 1'b0;
        while (fet_gate == 0 && (blanks + latches) < gap_max) begin
            if (sr_latch) latches++;
            else          blanks++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_first_row();
        logic [7:0] bits;
        logic       prev;
        int         rises, idle, lat, n;
        rst = 1'b1; run = 1'b1; wr_en = 1'b1; wr_row = 4'd0; wr_data = 8'hA5; swap = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({sr_data, sr_clock, sr_latch, sr_enable, fet_gate, frame_start, swap_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got fet=%h clk=%b latch=%b en=%b, expected all 0",
                     fet_gate, sr_clock, sr_latch, sr_enable);
        end
        rst = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
        bits = '0; prev = 1'b0; rises = 0; idle = 0; lat = 0; n = 0;
        while (fet_gate == 0 && n < 100) begin
            if (sr_clock && !prev) begin
                bits = {bits[6:0], sr_data};
                rises++;
            end
            if (rises == 8 && !sr_clock && !sr_latch) idle++;
            if (sr_latch) lat++;
            prev = sr_clock;
            n++;
            @(negedge clk);
        end
        checks++;
        if (rises != 8) begin errors++; $display("FAIL preload_rises: got %0d expected 8", rises); end
        checks++;
        if (bits !== FIRST_EXP) begin errors++; $display("FAIL preload_data: got %h expected %h", bits, FIRST_EXP); end
        checks++;
        if (idle != 2) begin errors++; $display("FAIL preload_blank: got %0d expected 2", idle); end
        checks++;
        if (lat != 1) begin errors++; $display("FAIL preload_latch: got %0d expected 1", lat); end
        checks++;
        if (fet_gate !== 14'h0001 || sr_enable !== 1'b1 || frame_start !== 1'b1) begin
            errors++;
            $display("FAIL row0_on: got fet=%h en=%b fs=%b expected 0001 1 1", fet_gate, sr_enable, frame_start);
        end
    endtask

    task automatic test_free_run();
        int on_len, nrise, blanks, latches, fs0, sd0;
        logic [7:0] shifted, expd;
        fs0 = fs_cnt; sd0 = sd_cnt;
        for (int r = 0; r < 14; r++) begin
            run_row(r, (r == 1 || r == 2) ? 5 : -1, 4'd3, (r == 1) ? 8'hFF : 8'h00,
                    -1, (r == 7) ? 5 : -1, 100, on_len, shifted, nrise, blanks, latches);
            expd = (r == 2) ? 8'hFF : (r == 13) ? 8'hA5 : 8'h00;
            checks++;
            if (on_len != 40) begin errors++; $display("FAIL run_on_len row%0d: got %0d expected 40", r, on_len); end
            checks++;
            if (blanks != 2 || latches != 1) begin
                errors++;
                $display("FAIL run_gap row%0d: got blank %0d latch %0d expected 2 1", r, blanks, latches);
            end
            checks++;
            if (nrise != 8 || shifted !== expd) begin
                errors++;
                $display("FAIL run_shift row%0d: got %0d rises data %h expected 8 %h", r, nrise, shifted, expd);
            end
        end
        checks++;
        if (fet_gate !== 14'h0001) begin errors++; $display("FAIL wrap: got %h expected 0001", fet_gate); end
        checks++;
        if (fs_cnt - fs0 != 1) begin errors++; $display("FAIL frame_start_count: got %0d expected 1", fs_cnt - fs0); end
        checks++;
        if (sd_cnt - sd0 != 0) begin errors++; $display("FAIL swap_ignored: got %0d expected 0", sd_cnt - sd0); end
    endtask

    task automatic test_run_stop();
        int on_len, nrise, blanks, latches;
        logic [7:0] shifted;
        for (int r = 0; r < 5; r++) begin
            run_row(r, -1, 4'd0, 8'h00, -1, -1, 100, on_len, shifted, nrise, blanks, latches);
            checks++;
            if (on_len != 40 || shifted !== 8'h00) begin
                errors++;
                $display("FAIL frame2 row%0d: got len %0d data %h expected 40 00", r, on_len, shifted);
            end
        end
        run_row(5, -1, 4'd0, 8'h00, 5, -1, 30, on_len, shifted, nrise, blanks, latches);
        checks++;
        if (on_len != 40) begin errors++; $display("FAIL stop_finish: got %0d expected 40", on_len); end
        checks++;
        if (blanks != 30 || latches != 0 || sr_enable !== 1'b0 || fet_gate !== '0) begin
            errors++;
            $display("FAIL parked: got blank %0d latch %0d en %b fet %h expected 30 0 0 0",
                     blanks, latches, sr_enable, fet_gate);
        end
        run = 1'b1;
        @(negedge clk);
        checks++;
        if (sr_latch !== 1'b1 || fet_gate !== '0) begin
            errors++; $display("FAIL resume_latch: got latch %b fet %h expected 1 0", sr_latch, fet_gate);
        end
        @(negedge clk);
        checks++;
        if (fet_gate !== 14'h0040 || sr_enable !== 1'b1) begin
            errors++; $display("FAIL resume_row6: got %h en %b expected 0040 1", fet_gate, sr_enable);
        end
        run_row(6, -1, 4'd0, 8'h00, -1, -1, 100, on_len, shifted, nrise, blanks, latches);
        checks++;
        if (on_len != 40) begin errors++; $display("FAIL row6_len: got %0d expected 40", on_len); end
    endtask

    task automatic test_short_on();
        int n, len, gap;
        logic [13:0] cur;
        n = 0;
        while (s_fet_gate != 0 && n < 200) begin n++; @(negedge clk); end
        n = 0;
        while (s_fet_gate == 0 && n < 200) begin n++; @(negedge clk); end
        for (int k = 0; k < 3; k++) begin
            cur = s_fet_gate; len = 0; gap = 0;
            while (s_fet_gate == cur && cur != 0 && len < 200) begin len++; @(negedge clk); end
            while (s_fet_gate == 0 && gap < 200) begin gap++; @(negedge clk); end
            checks++;
            if (len != 16) begin errors++; $display("FAIL short_on_len %0d: got %0d expected 16", k, len); end
            checks++;
            if (gap != 3) begin errors++; $display("FAIL short_gap %0d: got %0d expected 3", k, gap); end
        end
    endtask

`ifdef FRAME_DBUF_EN
    task automatic test_dbuf();
        int on_len, nrise, blanks, latches, sd0, wat;
        logic [7:0] shifted, expd, wd;
        logic [3:0] wr;
        sd0 = sd_cnt;
        for (int r = 0; r < 14; r++) begin
            wat = (r == 0 || r == 1 || r == 13) ? 5 : -1;
            wr  = (r == 0) ? 4'd0 : (r == 1) ? 4'd14 : 4'd1;
            wd  = (r == 0) ? 8'h3C : (r == 1) ? 8'hFF : 8'h81;
            run_row(r, wat, wr, wd, -1, (r == 7 || r == 9) ? 5 : -1, 100,
                    on_len, shifted, nrise, blanks, latches);
            expd = (r == 13) ? 8'h3C : 8'h00;
            checks++;
            if (on_len != 40 || shifted !== expd) begin
                errors++;
                $display("FAIL dbuf row%0d: got len %0d data %h expected 40 %h", r, on_len, shifted, expd);
            end
            if (r == 11) begin
                checks++;
                if (sd_cnt != sd0) begin errors++; $display("FAIL swap_early: got %0d expected 0", sd_cnt - sd0); end
            end
        end
        checks++;
        if (sd_cnt - sd0 != 1) begin errors++; $display("FAIL swap_done_count: got %0d expected 1", sd_cnt - sd0); end
        run_row(0, -1, 4'd0, 8'h00, -1, -1, 100, on_len, shifted, nrise, blanks, latches);
        checks++;
        if (shifted !== 8'h00) begin errors++; $display("FAIL back_bank_write: got %h expected 00", shifted); end
    endtask
`endif

    task automatic test_reset_mid();
        int n, rises;
        logic [7:0] bits;
        logic prev;
        n = 0;
        while (!sr_clock && n < 200) begin n++; @(negedge clk); end
        checks++;
        if (!sr_clock) begin errors++; $display("FAIL wait_shift: got timeout expected sr_clock high"); end
        rst = 1'b1;
        #1;
        checks++;
        if ({sr_data, sr_clock, sr_latch, sr_enable, fet_gate, frame_start, swap_done} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got fet=%h clk=%b en=%b expected all 0", fet_gate, sr_clock, sr_enable);
        end
        @(negedge clk);
        rst = 1'b0;
        bits = '0; prev = 1'b0; rises = 0; n = 0;
        while (rises < 8 && n < 60) begin
            if (sr_clock && !prev) begin bits = {bits[6:0], sr_data}; rises++; end
            prev = sr_clock;
            n++;
            @(negedge clk);
        end
        checks++;
        if (rises != 8 || bits !== 8'h00) begin
            errors++; $display("FAIL ram_cleared: got %0d rises data %h expected 8 00", rises, bits);
        end
    endtask

    initial begin
        test_reset_first_row();
`ifdef FRAME_DBUF_EN
        test_dbuf();
`else
        test_free_run();
        test_run_stop();
        test_short_on();
`endif
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (hazard != 0) begin errors++; $display("FAIL invariants: got %0d violations expected 0", hazard); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
